// File: rtl/fp_pkg.sv
// fp_pkg: state encoding, flag positions and canonical NaNs shared by the FP issue path.
package fp_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_e;
    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_ISSUE = S_ISSUE;
    localparam logic [1:0] ST_WAIT  = S_WAIT;
    localparam logic [1:0] ST_RESP  = S_RESP;
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;
    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [15:0] QNAN_HP = 16'h7E00;
    localparam logic MODE_SINGLE = 1'b1;
    localparam logic MODE_HALF   = 1'b0;

    function automatic logic [31:0] fit_mode(input logic mode, input logic [31:0] v);
        return mode == MODE_SINGLE ? v : {16'h0, v[15:0]};
    endfunction

    function automatic logic [31:0] qnan(input logic mode);
        return mode == MODE_SINGLE ? QNAN_SP : {16'h0, QNAN_HP};
    endfunction
endpackage

// File: rtl/fp_issue_ctrl_if.sv
// fp_issue_ctrl_if: request, adder and response signals of the FP issue controller.
interface fp_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic             req_sub;
    logic             req_mode_fp;
    logic             req_round_mode;
    logic [TAG_W-1:0] req_tag;
    logic             add_start;
    logic [31:0]      add_op_a;
    logic [31:0]      add_op_b;
    logic             add_sub;
    logic             add_mode_fp;
    logic             add_round_mode;
    logic             add_ready_out;
    logic             add_ready_in;
    logic             add_valid_out;
    logic [31:0]      add_result;
    logic [4:0]       add_flags;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic [4:0]       flags_sticky;
    logic             flags_clr;
    logic             timeout_err;
    logic [15:0]      op_count;

    // controller side
    modport slave (
        input  req_valid, req_a, req_b, req_sub, req_mode_fp, req_round_mode, req_tag,
        input  add_ready_out, add_valid_out, add_result, add_flags,
        input  rsp_ready, flags_clr,
        output req_ready, add_start, add_op_a, add_op_b, add_sub, add_mode_fp, add_round_mode,
        output add_ready_in, rsp_valid, rsp_result, rsp_flags, rsp_tag,
        output flags_sticky, timeout_err, op_count
    );

    // sequencer / adder side
    modport master (
        output req_valid, req_a, req_b, req_sub, req_mode_fp, req_round_mode, req_tag,
        output add_ready_out, add_valid_out, add_result, add_flags,
        output rsp_ready, flags_clr,
        input  req_ready, add_start, add_op_a, add_op_b, add_sub, add_mode_fp, add_round_mode,
        input  add_ready_in, rsp_valid, rsp_result, rsp_flags, rsp_tag,
        input  flags_sticky, timeout_err, op_count
    );
endinterface

// File: rtl/fp_issue_ctrl_watchdog_cnt.sv
// watchdog_cnt: loadable down-counter that flags expiry when one tick remains.
module watchdog_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end

    // expiry is acted on at the edge that would consume the last tick
    assign expired = en && cnt == W'(1);
endmodule

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl: issues one tagged request at a time to fp_adder and returns the result,
// keeping sticky flags, a completion count and a watchdog that substitutes a qNaN.
module fp_issue_ctrl
    import fp_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst_n,
    fp_issue_ctrl_if.slave bus
);
    logic [1:0]       state, state_nxt;
    logic [31:0]      op_a, op_b, rsp_result;
    logic             sub, mode_fp, round_mode, timeout_err;
    logic [TAG_W-1:0] tag;
    logic [4:0]       rsp_flags, flags_sticky, cap_flags;
    logic [15:0]      op_count;
    logic             accept, busy, expired, capture, expire, resp_enter;

    assign accept     = state == ST_IDLE && bus.req_valid;
    assign busy       = state == ST_ISSUE || state == ST_WAIT;
    assign capture    = state == ST_WAIT && bus.add_valid_out;
    // a result arriving on the expiry edge still wins
    assign expire     = busy && expired && !capture;
    assign resp_enter = capture || expire;
    assign cap_flags  = capture ? bus.add_flags : 5'(1 << FLAG_NV);

    watchdog_cnt #(.W(16)) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (16'(TIMEOUT)),
        .en       (busy),
        .expired  (expired)
    );

    always_comb begin
        state_nxt = state == ST_IDLE  ? (bus.req_valid ? ST_ISSUE : ST_IDLE) :
                    resp_enter        ? ST_RESP :
                    state == ST_ISSUE ? (bus.add_ready_out ? ST_WAIT : ST_ISSUE) :
                    state == ST_RESP  ? (bus.rsp_ready ? ST_IDLE : ST_RESP) : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_a         <= '0;
            op_b         <= '0;
            sub          <= 1'b0;
            mode_fp      <= 1'b0;
            round_mode   <= 1'b0;
            tag          <= '0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            flags_sticky <= '0;
            timeout_err  <= 1'b0;
            op_count     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a       <= fit_mode(bus.req_mode_fp, bus.req_a);
                op_b       <= fit_mode(bus.req_mode_fp, bus.req_b);
                sub        <= bus.req_sub;
                mode_fp    <= bus.req_mode_fp;
                round_mode <= bus.req_round_mode;
                tag        <= bus.req_tag;
            end
            // a clear coinciding with a capture leaves exactly the new flags
            if (resp_enter) begin
                rsp_result   <= capture ? fit_mode(mode_fp, bus.add_result) : qnan(mode_fp);
                rsp_flags    <= cap_flags;
                flags_sticky <= (bus.flags_clr ? 5'h0 : flags_sticky) | cap_flags;
                timeout_err  <= (bus.flags_clr ? 1'b0 : timeout_err) | expire;
                op_count     <= op_count + 16'd1;
            end else if (bus.flags_clr) begin
                flags_sticky <= '0;
                timeout_err  <= 1'b0;
            end
        end
    end

    assign bus.req_ready      = state == ST_IDLE;
    assign bus.add_start      = state == ST_ISSUE;
    assign bus.add_ready_in   = state == ST_WAIT;
    assign bus.rsp_valid      = state == ST_RESP;
    assign bus.add_op_a       = op_a;
    assign bus.add_op_b       = op_b;
    assign bus.add_sub        = sub;
    assign bus.add_mode_fp    = mode_fp;
    assign bus.add_round_mode = round_mode;
    assign bus.rsp_result     = rsp_result;
    assign bus.rsp_flags      = rsp_flags;
    assign bus.rsp_tag        = tag;
    assign bus.flags_sticky   = flags_sticky;
    assign bus.timeout_err    = timeout_err;
    assign bus.op_count       = op_count;
endmodule

// File: doc/fp_issue_ctrl.md
# fp_issue_ctrl

Initiator for the FP adder's start/ready/valid protocol. Accepts tagged operation requests from an upstream valid/ready port, drives one operation at a time into `fp_adder`, waits for its result, and returns result, flags and tag downstream. Keeps sticky exception flags, a completion counter and a watchdog timeout, and sits between the instruction sequencer and the adder.

## Interface
- `TAG_W`, 4: width of the request/response tag.
- `TIMEOUT`, 64: cycles allowed from entering ISSUE to result capture; range 2..65535.
- `clk` in 1: clock, rising edge. One clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1, `req_ready` out 1: upstream handshake.
- `req_a`, `req_b` in 32: operands. Half mode uses bits [15:0]; [31:16] ignored.
- `req_sub`, `req_mode_fp`, `req_round_mode` in 1 each: subtract; 1 = single, 0 = half; 0 = nearest-even.
- `req_tag` in TAG_W: opaque tag, returned unchanged.
- `add_start` out 1; `add_op_a`, `add_op_b` out 32; `add_sub`, `add_mode_fp`, `add_round_mode` out 1 each: adder command.
- `add_ready_out` in 1: adder can accept a command.
- `add_ready_in` out 1: result backpressure to the adder.
- `add_valid_out` in 1, `add_result` in 32, `add_flags` in 5: adder result.
- `rsp_valid` out 1, `rsp_ready` in 1: downstream handshake.
- `rsp_result` out 32, `rsp_flags` out 5, `rsp_tag` out TAG_W: response payload.
- `flags_sticky` out 5: OR of all returned flags. `flags_clr` in 1 clears it.
- `timeout_err` out 1: sticky watchdog error. Cleared by `flags_clr`.
- `op_count` out 16: number of completed responses. Wraps from FFFF to 0000.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1 in IDLE only.
  - On `req_valid && req_ready` at an edge: latch all `req_*` fields. In half mode, zero operand bits [31:16]. Clear the watchdog. Go to ISSUE.
- **ISSUE**
  - `add_start` = 1. `add_*` outputs driven from the latched request.
  - At an edge with `add_ready_out` = 1, the command is accepted. Go to WAIT.
- **WAIT**
  - `add_ready_in` = 1.
  - At an edge with `add_valid_out` = 1: capture `add_result` and `add_flags`. In half mode, force captured [31:16] to 0. Go to RESP.
- **RESP**
  - `rsp_valid` = 1. Payload is stable until accepted. `add_ready_in` = 0.
  - On `rsp_ready`: go to IDLE.
- **Watchdog**
  - Counts every cycle in ISSUE and WAIT.
  - If the count reaches TIMEOUT before capture, go to RESP with a canonical qNaN: 7FC0_0000 in single mode, 0000_7E00 in half mode.
  - Flags for that response = FLAG_NV only. Set `timeout_err`.
  - A late `add_valid_out` outside WAIT is ignored, since `add_ready_in` = 0.
- **Counters and sticky flags**
  - `op_count` increments on each RESP entry, including timeouts.
  - `flags_sticky |= captured flags` on RESP entry.
  - If `flags_clr` coincides with a capture, the new value is exactly the captured flags. Same rule for `timeout_err`.
- Capture (WAIT) and timeout expiry on the same edge: the capture wins.
- `add_op_*` and `add_sub`/`add_mode_fp`/`add_round_mode` hold their values in all states. They change only on request acceptance.

## Timing
- Reset values: state IDLE. `req_ready` = 1 (combinational from IDLE). `add_start` = 0, `add_ready_in` = 0, `rsp_valid` = 0.
- Reset values, continued: all `add_op_*`, `rsp_*` payload, `flags_sticky`, `timeout_err` and `op_count` = 0.
- Reset asserted mid-operation returns to IDLE immediately. The pending request is dropped and no response is issued.
- All outputs are registered or decoded from the state only. There is no combinational path from `req_*` or `rsp_ready` to any output.
- Latency with the adder ready:
  - request accepted at edge E; `add_start` high in cycle E+1;
  - command accepted at edge E+1;
  - adder latency L → capture at edge E+1+L;
  - `rsp_valid` high from E+1+L.
- With immediate `rsp_ready`: minimum 3+L cycles per operation. No overlap between operations.

## Structure
- Shared package `fp_pkg`:
  - state enum;
  - flag bit indices FLAG_NV=4, FLAG_DZ=3, FLAG_OF=2, FLAG_UF=1, FLAG_NX=0;
  - QNAN_SP = 32'h7FC0_0000 and QNAN_HP = 16'h7E00;
  - MODE_SINGLE = 1, MODE_HALF = 0.
- One sub-module: `watchdog_cnt` (load/enable/expired; 16-bit down-counter).

## Test plan
- Single 41A6_0000 + 4010_0000, with `fp_adder` connected: `rsp_result` = 41B8_0000, `rsp_tag` echoed, `op_count` = 1.
- Single 7F80_0000 + FF80_0000 → 7FC0_0000 with FLAG_NV set. Then 4160_0000 + C144_0000 → 3FE0_0000.
  - `flags_sticky` keeps NV.
  - `flags_clr` pulsed with a third capture: sticky = that op's flags only.
- Half 4680 + 4EB0 with `req_a` [31:16] = FFFF → adder sees 0000_4680, response 0000_5028.
- `rsp_ready` low for 5 cycles in RESP → payload stable, `req_ready` = 0, `add_ready_in` = 0. Next request is accepted only after `rsp_ready`.
- Stub adder never asserts `add_valid_out`, TIMEOUT = 8, single mode:
  - response arrives 8 cycles after entering ISSUE;
  - result 7FC0_0000, flags 10000;
  - `timeout_err` = 1.
- `rst_n` pulsed while in WAIT → all outputs at reset values, no `rsp_valid`. The next request completes normally.
